// File: rtl/baud_cfg_sequencer.sv
// Arbitrates switch and host divisor requests and writes each winning divisor
// into the baud generator as a low-byte then high-byte load, once the transmitter is idle.
module baud_cfg_sequencer #(
  parameter logic [15:0] DIV0     = 16'd1301,
  parameter logic [15:0] DIV1     = 16'd650,
  parameter logic [15:0] DIV2     = 16'd324,
  parameter logic [15:0] DIV3     = 16'd161,
  parameter logic [7:0]  DEBOUNCE = 8'd16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  br_cfg,
  input  logic        host_req,
  input  logic [15:0] host_div,
  output logic        host_ack,
  input  logic        tx_idle,
  output logic        baud_load,
  output logic [1:0]  ioaddr,
  output logic [7:0]  baud_gen,
  output logic        busy,
  output logic        cfg_done,
  output logic [15:0] cur_div
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WAIT_TX = 3'd1;
  localparam logic [2:0] S_LOAD_LO = 3'd2;
  localparam logic [2:0] S_LOAD_HI = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [1:0]  br_s1;
  logic [1:0]  br_sync;
  logic [1:0]  br_hist;
  logic [1:0]  br_applied;
  logic [7:0]  db_cnt;
  logic        sw_pending;
  logic [1:0]  warm;
  logic [2:0]  state;
  logic [15:0] div_q;
  logic        grant_ok;
  logic        grant_sw;
  logic        grant_host;
  logic        debounced;

  function automatic logic [15:0] sel_div(input logic [1:0] cfg);
    case (cfg)
      2'b00:   sel_div = DIV0;
      2'b01:   sel_div = DIV1;
      2'b10:   sel_div = DIV2;
      default: sel_div = DIV3;
    endcase
  endfunction

  // Grants wait until the synchronizer has filled so the first load sees the real switches
  assign grant_ok   = (state == S_IDLE) && (warm == 2'd2);
  assign grant_sw   = grant_ok && sw_pending;
  assign grant_host = grant_ok && !sw_pending && host_req;
  assign debounced  = (br_sync == br_hist) && (br_sync != br_applied) &&
                      (db_cnt == DEBOUNCE - 8'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_s1      <= 2'b00;
      br_sync    <= 2'b00;
      br_hist    <= 2'b00;
      br_applied <= 2'b00;
      db_cnt     <= 8'd0;
      sw_pending <= 1'b1;
      warm       <= 2'd0;
    end else begin
      br_s1   <= br_cfg;
      br_sync <= br_s1;
      br_hist <= br_sync;
      if (warm != 2'd2) warm <= warm + 2'd1;
      // Count saturates at DEBOUNCE so a held setting raises sw_pending only once
      if (br_sync != br_hist || br_sync == br_applied) db_cnt <= 8'd0;
      else if (db_cnt < DEBOUNCE) db_cnt <= db_cnt + 8'd1;
      if (grant_sw) begin
        sw_pending <= 1'b0;
        br_applied <= br_sync;
      end else if (debounced) begin
        sw_pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (grant_sw)        div_q <= sel_div(br_sync);
    else if (grant_host) div_q <= host_div;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      host_ack  <= 1'b0;
      baud_load <= 1'b0;
      ioaddr    <= 2'b00;
      baud_gen  <= 8'h00;
      busy      <= 1'b0;
      cfg_done  <= 1'b0;
      cur_div   <= 16'h0000;
    end else begin
      host_ack  <= 1'b0;
      baud_load <= 1'b0;
      ioaddr    <= 2'b00;
      baud_gen  <= 8'h00;
      cfg_done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_sw || grant_host) begin
            host_ack <= grant_host;
            busy     <= 1'b1;
            state    <= S_WAIT_TX;
          end
        end
        S_WAIT_TX: if (tx_idle) state <= S_LOAD_LO;
        S_LOAD_LO: begin
          baud_load <= 1'b1;
          ioaddr    <= 2'b10;
          baud_gen  <= div_q[7:0];
          state     <= S_LOAD_HI;
        end
        S_LOAD_HI: begin
          baud_load <= 1'b1;
          ioaddr    <= 2'b11;
          baud_gen  <= div_q[15:8];
          state     <= S_DONE;
        end
        S_DONE: begin
          cur_div  <= div_q;
          cfg_done <= 1'b1;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/baud_cfg_sequencer.md
# baud_cfg_sequencer

Sequences divisor loads into the SPART baud generator. Arbitrates between two requesters, the debounced board baud-select switches and a host divisor request. Each winning 16-bit divisor is written as two byte loads on the generator's load/address/data port, low byte (addr 2'b10) then high byte (addr 2'b11). Loads are deferred until the transmitter reports idle, so a character is never split across two baud rates.

## Interface
Parameters:
- DIV0, 16'd1301, divisor for br_cfg=2'b00 (4800 baud at 100 MHz, x16 oversample)
- DIV1, 16'd650, divisor for br_cfg=2'b01 (9600)
- DIV2, 16'd324, divisor for br_cfg=2'b10 (19200)
- DIV3, 16'd161, divisor for br_cfg=2'b11 (38400)
- DEBOUNCE, 8'd16, cycles synchronized br_cfg must hold a new value before a switch request is raised (1..255)

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  reset, asynchronous, active-high
- br_cfg  in  2  baud-select switches, asynchronous to clk
- host_req  in  1  host divisor request, level; held until host_ack
- host_div  in  16  host divisor; stable while host_req=1
- host_ack  out  1  one-cycle pulse: host request granted, host_div captured
- tx_idle  in  1  transmitter idle (no character in flight)
- baud_load  out  1  generator load strobe
- ioaddr  out  2  generator register address (2'b10 low, 2'b11 high, else 2'b00)
- baud_gen  out  8  generator load data byte
- busy  out  1  high from grant until sequence completes
- cfg_done  out  1  one-cycle pulse on completion of a two-byte load
- cur_div  out  16  last divisor fully loaded

## Operation
- All outputs are registered. Reset values: host_ack=0, baud_load=0, ioaddr=2'b00, baud_gen=8'h00, busy=0, cfg_done=0, cur_div=16'h0000. State resets to IDLE, debounce counter to 0, and sw_pending to 1, so the switch setting is always loaded after reset.
- br_cfg passes through a 2-flop synchronizer to give br_sync. The synchronizer flops reset to 2'b00.
- Switch change detection:
  - br_sync != br_applied and unchanged for DEBOUNCE consecutive cycles sets sw_pending.
  - Any change of br_sync restarts the count.
  - br_applied is updated to br_sync when a switch request is granted.
- States:
  - IDLE:
    - If sw_pending=1, grant the switch requester: latch div_q = DIVn(br_sync), clear sw_pending.
    - Else if host_req=1, grant the host: latch div_q = host_div, pulse host_ack.
    - On either grant, set busy=1 and go to WAIT_TX.
  - WAIT_TX: stay while tx_idle=0. When tx_idle=1, go to LOAD_LO.
  - LOAD_LO: baud_load=1, ioaddr=2'b10, baud_gen=div_q[7:0]. Next state LOAD_HI.
  - LOAD_HI: baud_load=1, ioaddr=2'b11, baud_gen=div_q[15:8]. Next state DONE.
  - DONE:
    - baud_load=0, ioaddr=2'b00, baud_gen=8'h00.
    - cur_div=div_q, cfg_done=1 (one cycle), busy=0.
    - Next state IDLE.
- Arbitration:
  - Fixed priority: switch over host. Requests only win when sampled in IDLE.
  - A host_req held during a switch sequence is granted on the first IDLE cycle after DONE.
  - host_ack is issued exactly once per grant. The host must drop host_req the cycle after host_ack, or it is regranted.
- A switch change that debounces during a sequence sets sw_pending and is serviced after the current sequence. It is never merged into the one in flight.
- An equal divisor is still loaded; no suppression of redundant loads.
- Asynchronous rst in any state immediately forces all outputs to reset values and returns to IDLE with sw_pending=1. A partially written divisor is not completed.

## Timing
- Grant in IDLE at edge N. Then:
  - If tx_idle=1: baud_load high at edges N+2 (low byte) and N+3 (high byte); cfg_done and cur_div update at N+4; IDLE again from N+4.
  - Each cycle of tx_idle=0 in WAIT_TX adds one cycle.
- baud_load is exactly 2 consecutive cycles per sequence and never asserted outside LOAD_LO/LOAD_HI.
- tx_idle is sampled only in WAIT_TX. Dropping it after LOAD_LO starts does not stall the load.
- First post-reset load: 2 sync cycles, then IDLE grant (sw_pending preset, debounce bypassed), then the loads.
- Back-to-back sequences: minimum 5 cycles grant-to-grant.

## Test plan
- Reset release, br_cfg=2'b01, tx_idle=1 -> two baud_load cycles with (2'b10, 8'h8A) then (2'b11, 8'h02); cfg_done pulse; cur_div=16'd650.
- Host request host_div=16'h1234, tx_idle=0 for 10 cycles then 1 -> host_ack one pulse at grant; no baud_load while tx_idle=0; then loads 8'h34, 8'h12; cur_div=16'h1234.
- br_cfg toggles 01->11 but bounces back before 16 cycles -> no sequence; held 11 for 16 cycles -> loads 8'hA1, 8'h00; cur_div=16'd161.
- Switch change and host_req in same IDLE cycle -> switch sequence first (no host_ack yet), then host sequence beginning ≤1 cycle after DONE; exactly one host_ack.
- Assert rst between the LOAD_LO and LOAD_HI cycles -> baud_load=0, busy=0, cur_div=0 immediately. After release, a full switch-divisor sequence is reissued.
- Host request arrives during WAIT_TX of a switch sequence -> serviced after cfg_done; cur_div ends at host_div.
